reg_wb_queue: RTL

Write-side initiator for the 16x16 register file. It collects writeback results from two producers, the ALU and the memory unit, into a small in-order queue. It drains one entry per cycle onto the register file's single write port (C/Caddr/Load). It also flags read-after-write hazards for the two register-file read addresses, so decode can stall.

---
 rtl/reg_wb_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_wb_queue.sv
// Writeback queue feeding the register file's single write port. It merges ALU and memory results in order
// and flags read-after-write hazards for the two read ports.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic                         clk,
  input  logic                         Clear,
  input  logic                         mem_valid,
  input  logic [AW-1:0]                mem_addr,
  input  logic [DW-1:0]                mem_data,
  output logic                         mem_ready,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_addr,
  input  logic [DW-1:0]                alu_data,
  output logic                         alu_ready,
  output logic [DW-1:0]                C,
  output logic [AW-1:0]                Caddr,
  output logic                         Load,
  input  logic [AW-1:0]                Aaddr,
  input  logic [AW-1:0]                Baddr,
  output logic                         hazA,
  output logic                         hazB,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Handshake: a producer's entry is taken at a rising edge where its valid and ready are both 1.
  // ready depends only on the registered count and on mem_valid, never on the producer's own valid.
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] alu_slot;
  logic [CW-1:0] free;
  logic          push_mem;
  logic          push_alu;
  logic          pop;

  // Free space uses the pre-edge count, so a same-cycle pop gives no credit.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = mem_valid ? (free >= CW'(2)) : (free >= CW'(1));

  assign push_mem = mem_valid && mem_ready;
  assign push_alu = alu_valid && alu_ready;
  assign pop      = (count != '0);

  // The memory result is the older instruction, so it takes the tail slot first.
  assign alu_slot = push_mem ? tail + PW'(1) : tail;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push_mem) begin
      addr_q[tail] <= mem_addr;
      data_q[tail] <= mem_data;
    end
    if (push_alu) begin
      addr_q[alu_slot] <= alu_addr;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      Load  <= 1'b0;
      Caddr <= '0;
      C     <= '0;
    end else begin
      tail  <= tail + PW'(push_mem) + PW'(push_alu);
      count <= count + CW'(push_mem) + CW'(push_alu) - CW'(pop);
      if (pop) begin
        Load  <= 1'b1;
        Caddr <= addr_q[head];
        C     <= data_q[head];
        head  <= head + PW'(1);
      end else begin
        Load  <= 1'b0;
      end
    end
  end

  // A slot is occupied when its distance from head is less than count; the output register also counts while Load is high.
  always_comb begin
    logic [PW-1:0] off;
    hazA = Load && (Caddr == Aaddr);
    hazB = Load && (Caddr == Baddr);
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if (CW'(off) < count) begin
        if (addr_q[i] == Aaddr) hazA = 1'b1;
        if (addr_q[i] == Baddr) hazB = 1'b1;
      end
    end
  end

endmodule
